down_counter_timer16: RTL and testbench
=======================================

Name: down_counter_timer16

Overview:
- Loadable, pausable 16-bit countdown timer.
- Holds a count register that feeds a combinational subtract-one datapath each cycle and registers the result back.
- Flags terminal count with a done handshake; optionally reloads for periodic operation.
- Consumer-side stage of the team's ripple decrement logic, for use as a delay/interval generator.

Parameters:
WIDTH, 16, count and load width in bits
AUTO_RELOAD, 0, 0 = one-shot (stop in DONE), 1 = periodic (reload last load value at terminal count)

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  when high, capture load_value at the next edge; highest priority
load_value  input  WIDTH  start value of the countdown
en  input  1  count enable; low pauses in RUN
ack  input  1  clears done in one-shot mode
count  output  WIDTH  current count register
busy  output  1  high while in RUN
done  output  1  terminal-count flag

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, reload_reg=0, busy=0, done=0.
  - Applies immediately, regardless of clk.
  - Mid-count reset discards all progress; no done is produced.
- States: IDLE, RUN, DONE. Outputs are registered; busy=(state==RUN).
- Priority at each edge: load > ack > en.
- load=1, any state:
  - count<=load_value; reload_reg<=load_value; done<=0.
  - load_value!=0: next state RUN.
  - load_value==0: next state DONE with done<=1 on the same edge (zero-length timer).
- IDLE: count holds. en and ack are ignored.
- RUN, en=0: count and state hold (pause).
- RUN, en=1, count>1: count<=count-1 via the decrement datapath.
- RUN, en=1, count==1:
  - One-shot: count<=0, state<=DONE, done<=1.
  - AUTO_RELOAD=1: count<=reload_reg, state stays RUN, done is a 1-cycle pulse.
- Latency:
  - Load at edge k with en held high: count==0 and done==1 after edge k+N.
  - Each cycle with en=0 during RUN adds one cycle.
- DONE (one-shot): count stays 0, busy=0, done stays 1.
  - ack=1: done<=0, state<=IDLE.
  - en is ignored; no wrap to all-ones.
- AUTO_RELOAD=1: ack is ignored; done never stays high longer than one cycle, except for the load-zero case, which enters DONE and behaves as one-shot.
- Arithmetic:
  - Decrement is unsigned modulo 2^WIDTH, but the FSM guarantees it is never applied to 0.
  - The datapath borrow-out is unused.
  - Max load 16'hFFFF gives 65535 counting cycles.
- Simultaneous events:
  - load+ack in DONE: load wins, done<=0, new count.
  - load on the terminal-count edge: load wins, no done pulse.
  - ack in RUN: ignored.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH constant.
- Sub-module dec_step: purely combinational WIDTH-bit subtract-one.
  - Ripple of full-adder cells, adding all-ones with carry-in 0.
  - Outputs next value and borrow-out; instantiated once.
- Top-level module: the registers, next-state logic and output logic.

Test Plan:
- Reset: assert rst mid-RUN with count=0x0005 → count=0, busy=0, done=0 immediately, without waiting for a clk edge.
- One-shot: load 0x0003 with en=1 held.
  - Count sequence 3,2,1,0 on consecutive edges; busy high for 3 cycles.
  - done=1 and holds until ack; ack returns to IDLE with done=0.
- Pause: load 0x0004, en low for 2 cycles after the first decrement → done rises exactly 6 cycles after load; count is held at 3 during the pause.
- Zero and max:
  - load 0x0000 → done=1 after one edge, busy never high.
  - load 0xFFFF → done after exactly 65535 enabled cycles; count never wraps to 0xFFFF afterwards.
- Priority: load 0x0002 asserted on the terminal-count edge of a running count → no done pulse, count=2, state RUN.
  - Also: load+ack together in DONE → new count taken.
- AUTO_RELOAD=1: load 0x0003.
  - done pulses for one cycle every 3 enabled cycles.
  - Count sequence 3,2,1,3,2,1...; ack has no effect.

Source files
------------

// File: rtl/down_counter_timer16_pkg.sv
// Shared definitions for the down_counter_timer16 countdown timer.
// Holds the FSM state encoding and the default count width.
package down_counter_timer16_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter_timer16_dec_step.sv
// Combinational subtract-one: a ripple of full-adder cells adding all-ones
// with carry-in 0. borrow is high only when the input was zero.
module dec_step
    import down_counter_timer16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] dec_value,
    output logic             borrow
);

    logic [WIDTH:0] carry;

    // Full adder with b=1: sum = a ^ 1 ^ c, carry-out = a | c.
    always_comb begin
        carry     = '0;
        dec_value = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            dec_value[i] = value[i] ^ 1'b1 ^ carry[i];
            carry[i+1]   = value[i] | carry[i];
        end
        borrow = ~carry[WIDTH];
    end

endmodule

// File: rtl/down_counter_timer16.sv
// Loadable, pausable countdown timer with a terminal-count done flag and
// optional periodic reload of the last loaded value.
module down_counter_timer16
    import down_counter_timer16_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] dec_value;
    logic             borrow;

    dec_step #(
        .WIDTH(WIDTH)
    ) u_dec_step (
        .value    (count),
        .dec_value(dec_value),
        .borrow   (borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (load) begin
            count      <= load_value;
            reload_reg <= load_value;
            if (load_value == '0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                state <= RUN;
                busy  <= 1'b1;
                done  <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: ;
                RUN: begin
                    // done is only ever a one-cycle pulse while running
                    done <= 1'b0;
                    if (en) begin
                        if (count == WIDTH'(1)) begin
                            done <= 1'b1;
                            if (AUTO_RELOAD) begin
                                count <= reload_reg;
                            end else begin
                                count <= '0;
                                state <= DONE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            count <= dec_value;
                        end
                    end
                end
                DONE: begin
                    if (ack) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // RUN always holds a nonzero count, so the datapath never borrows there.
    a_no_borrow_in_run: assert property (
        @(posedge clk) disable iff (rst) (state == RUN) |-> !borrow
    );

    a_busy_matches_state: assert property (
        @(posedge clk) disable iff (rst) busy == (state == RUN)
    );

endmodule

// File: tb/tb_down_counter_timer16.sv
// Randomized and directed checks of one-shot and auto-reload timers against
// a behavioural countdown model.
module tb_down_counter_timer16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] load_value;
    logic         en;
    logic         ack;

    logic [W-1:0] count_os, count_ar;
    logic         busy_os, busy_ar, done_os, done_ar;

    int n_checks = 0;
    int n_fail   = 0;

    // model index 0 = one-shot, 1 = auto-reload
    int unsigned m_count [2];
    int unsigned m_period[2];
    bit          m_busy  [2];
    bit          m_done  [2];

    always #5 clk = ~clk;

    down_counter_timer16 #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_os (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value),
        .en(en), .ack(ack), .count(count_os), .busy(busy_os), .done(done_os)
    );

    down_counter_timer16 #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value),
        .en(en), .ack(ack), .count(count_ar), .busy(busy_ar), .done(done_ar)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_count[i] = 0; m_period[i] = 0; m_busy[i] = 0; m_done[i] = 0;
        end
    endfunction

    // Timer semantics: a loaded nonzero value runs down one per enabled cycle;
    // reaching the end either parks at zero (one-shot) or restarts the period.
    function automatic void model_step(input bit l, input int unsigned lv, input bit e, input bit a);
        for (int i = 0; i < 2; i++) begin
            if (l) begin
                m_count[i]  = lv;
                m_period[i] = lv;
                m_busy[i]   = (lv != 0);
                m_done[i]   = (lv == 0);
            end else if (m_busy[i]) begin
                m_done[i] = 0;
                if (e) begin
                    if (m_count[i] == 1) begin
                        m_done[i] = 1;
                        if (i == 1) m_count[i] = m_period[i];
                        else begin
                            m_count[i] = 0;
                            m_busy[i]  = 0;
                        end
                    end else begin
                        m_count[i] = (m_count[i] - 1) % 65536;
                    end
                end
            end else if (m_done[i] && a) begin
                m_done[i] = 0;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".os_count"}, {16'h0, count_os}, m_count[0]);
        check({tag, ".os_busy"},  {31'h0, busy_os},  {31'h0, m_busy[0]});
        check({tag, ".os_done"},  {31'h0, done_os},  {31'h0, m_done[0]});
        check({tag, ".ar_count"}, {16'h0, count_ar}, m_count[1]);
        check({tag, ".ar_busy"},  {31'h0, busy_ar},  {31'h0, m_busy[1]});
        check({tag, ".ar_done"},  {31'h0, done_ar},  {31'h0, m_done[1]});
    endtask

    task automatic cycle(input string tag, input bit l, input int unsigned lv, input bit e, input bit a);
        load = l; load_value = W'(lv); en = e; ack = a;
        @(posedge clk);
        #1;
        model_step(l, lv, e, a);
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_value = '0; en = 1'b0; ack = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        cycle("idle", 0, 0, 1, 1);

        // one-shot 3: 3,2,1,0 then done held until ack
        cycle("os3_load", 1, 3, 1, 0);
        check("os3_first", {16'h0, count_os}, 32'd3);
        for (int i = 0; i < 3; i++) cycle("os3_run", 0, 0, 1, 0);
        check("os3_done", {31'h0, done_os}, 32'd1);
        cycle("os3_hold", 0, 0, 1, 0);
        cycle("os3_ack", 0, 0, 1, 1);
        check("os3_acked", {31'h0, done_os}, 32'd0);

        // pause: load 4, one decrement, two paused cycles, then run out
        cycle("pause_load", 1, 4, 1, 0);
        cycle("pause_dec", 0, 0, 1, 0);
        cycle("pause_p1", 0, 0, 0, 0);
        cycle("pause_p2", 0, 0, 0, 1);
        check("pause_hold", {16'h0, count_os}, 32'd3);
        for (int i = 0; i < 3; i++) cycle("pause_run", 0, 0, 1, 0);
        check("pause_done6", {31'h0, done_os}, 32'd1);
        cycle("pause_ack", 0, 0, 0, 1);

        // zero-length timer
        cycle("zero_load", 1, 0, 1, 0);
        check("zero_done", {31'h0, done_os}, 32'd1);
        cycle("zero_hold", 0, 0, 1, 0);
        cycle("zero_ack", 0, 0, 1, 1);

        // load on terminal-count edge wins; then load+ack in DONE
        cycle("prio_load", 1, 2, 1, 0);
        cycle("prio_dec", 0, 0, 1, 0);
        cycle("prio_tc", 1, 2, 1, 0);
        check("prio_tc_done", {31'h0, done_os}, 32'd0);
        check("prio_tc_count", {16'h0, count_os}, 32'd2);
        cycle("prio_run1", 0, 0, 1, 0);
        cycle("prio_run2", 0, 0, 1, 0);
        cycle("prio_loadack", 1, 4, 0, 1);
        check("prio_la_count", {16'h0, count_os}, 32'd4);

        // auto-reload periodic run with ack toggling
        cycle("ar_load", 1, 3, 1, 0);
        for (int i = 0; i < 10; i++) cycle("ar_run", 0, 0, 1, i[0]);

        // asynchronous reset mid-run at count 5, no clock edge
        cycle("rst_load", 1, 5, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        cycle("post_rst", 0, 0, 1, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit          l, e, a;
            int unsigned lv;
            l  = ($urandom_range(0, 15) == 0);
            lv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 9);
            e  = ($urandom_range(0, 4) != 0);
            a  = ($urandom_range(0, 3) == 0);
            cycle("rand", l, lv, e, a);
        end

        // maximum load: 65535 enabled cycles, then no wrap
        cycle("max_load", 1, 16'hFFFF, 1, 0);
        for (int n = 0; n < 65535; n++) cycle("max_run", 0, 0, 1, 0);
        check("max_done", {31'h0, done_os}, 32'd1);
        check("max_zero", {16'h0, count_os}, 32'd0);
        for (int n = 0; n < 4; n++) cycle("max_nowrap", 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
